// File: rtl/register_file_sb_pkg.sv
// Shared constants and helpers for the architectural register file and its scoreboard.
package regfile_pkg;

   localparam int RF_WIDTH      = 32;
   localparam int RF_DEPTH      = 32;
   localparam int RF_READ_PORTS = 2;

   function automatic int rf_addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by an issuing producer, cleared by its writeback.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH    = RF_DEPTH,
   parameter int ZERO_REG = 1,
   parameter int ADDR_W   = rf_addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lock,
   input  logic [ADDR_W-1:0] lock_addr,
   input  logic              write,
   input  logic [ADDR_W-1:0] write_addr,
   output logic [DEPTH-1:0]  pending
);

   logic [DEPTH-1:0] pending_next;

   // A lock landing on the register being retired wins: the new producer owns it now.
   always_comb begin
      pending_next = pending;
      for (int r = 0; r < DEPTH; r++) begin
         if (lock && (lock_addr == ADDR_W'(r))) begin
            pending_next[r] = 1'b1;
         end else if (write && (write_addr == ADDR_W'(r))) begin
            pending_next[r] = 1'b0;
         end
      end
      if (ZERO_REG != 0) begin
         pending_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

endmodule

// File: rtl/register_file_sb.sv
// Multi-port architectural register file with optional write bypass, hardwired zero register
// and an integrated pending-write scoreboard feeding per-port busy flags.
module register_file_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH      = RF_WIDTH,
   parameter int DEPTH      = RF_DEPTH,
   parameter int READ_PORTS = RF_READ_PORTS,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1,
   localparam int ADDR_W    = rf_addr_w(DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write,
   input  logic [ADDR_W-1:0]            write_addr,
   input  logic [WIDTH-1:0]             write_data,
   input  logic [READ_PORTS*ADDR_W-1:0] read_addr,
   output logic [READ_PORTS*WIDTH-1:0]  read_data,
   output logic [READ_PORTS-1:0]        read_busy,
   input  logic                         lock,
   input  logic [ADDR_W-1:0]            lock_addr,
   output logic [DEPTH-1:0]             pending
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic             write_ok;

   assign write_ok = write && !((ZERO_REG != 0) && (write_addr == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
      end else if (write_ok) begin
         regs[write_addr] <= write_data;
      end
   end

   reg_scoreboard #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .lock       (lock),
      .lock_addr  (lock_addr),
      .write      (write),
      .write_addr (write_addr),
      .pending    (pending)
   );

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
      logic [ADDR_W-1:0] port_addr;
      logic [WIDTH-1:0]  port_data;

      assign port_addr = read_addr[p*ADDR_W +: ADDR_W];

      // Bypass is suppressed during reset so every port reads zero while reset is held.
      always_comb begin
         port_data = regs[port_addr];
         if ((BYPASS != 0) && write && !reset && (port_addr == write_addr)) begin
            port_data = write_data;
         end
         if ((ZERO_REG != 0) && (port_addr == '0)) begin
            port_data = '0;
         end
      end

      assign read_data[p*WIDTH +: WIDTH] = port_data;
      assign read_busy[p]                = pending[port_addr];
   end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed scenarios on the default build and a
// randomised sweep against a reference model on a wide, shallow, four-port, non-bypass build.
module tb_register_file_sb;

   logic clk;
   logic reset;

   // Default build: 32x32, 2 read ports, zero register, bypass on
   logic        w0;
   logic [4:0]  wa0;
   logic [31:0] wd0;
   logic [9:0]  ra0;
   logic [63:0] rd0;
   logic [1:0]  busy0;
   logic        lk0;
   logic [4:0]  la0;
   logic [31:0] pend0;

   // Sweep build: 64x8, 4 read ports, zero register, bypass off
   logic         w1;
   logic [2:0]   wa1;
   logic [63:0]  wd1;
   logic [11:0]  ra1;
   logic [255:0] rd1;
   logic [3:0]   busy1;
   logic         lk1;
   logic [2:0]   la1;
   logic [7:0]   pend1;

   int check_count;
   int error_count;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t exp_q[$];

   logic [63:0] model_mem [8];
   logic [7:0]  model_pend;

   register_file_sb dut0 (
      .clk        (clk),
      .reset      (reset),
      .write      (w0),
      .write_addr (wa0),
      .write_data (wd0),
      .read_addr  (ra0),
      .read_data  (rd0),
      .read_busy  (busy0),
      .lock       (lk0),
      .lock_addr  (la0),
      .pending    (pend0)
   );

   register_file_sb #(
      .WIDTH      (64),
      .DEPTH      (8),
      .READ_PORTS (4),
      .ZERO_REG   (1),
      .BYPASS     (0)
   ) dut1 (
      .clk        (clk),
      .reset      (reset),
      .write      (w1),
      .write_addr (wa1),
      .write_data (wd1),
      .read_addr  (ra1),
      .read_data  (rd1),
      .read_busy  (busy1),
      .lock       (lk1),
      .lock_addr  (la1),
      .pending    (pend1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic pushExpect(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic popCompare(input logic [63:0] observed);
      exp_t e;
      if (exp_q.size() == 0) begin
         check_count++;
         error_count++;
         $display("[TB] FAIL scoreboard_empty: got %h expected none", observed);
      end else begin
         e = exp_q.pop_front();
         checkOutput(e.tag, observed, e.val);
      end
   endtask

   task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic lk, input logic [4:0] la,
                                input logic [4:0] r0, input logic [4:0] r1);
      w0  = w;
      wa0 = wa;
      wd0 = wd;
      lk0 = lk;
      la0 = la;
      ra0 = {r1, r0};
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      w1 = 1'b0; wa1 = '0; wd1 = '0; ra1 = '0; lk1 = 1'b0; la1 = '0;
      #12;

      pushExpect("rst_rd", 64'd0);
      pushExpect("rst_pend0", 64'd0);
      pushExpect("rst_pend1", 64'd0);
      popCompare(rd0);
      popCompare(64'(pend0));
      popCompare(64'(pend1));
      reset = 1'b0;
      waitCycle();

      // Write and reserve r5, then assert reset between edges
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5, 5'd0);
      waitCycle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
      #1;
      pushExpect("t1_rd_before_reset", 64'hDEADBEEF);
      pushExpect("t1_pend_before_reset", 64'(32'h0000_0020));
      popCompare(64'(rd0[31:0]));
      popCompare(64'(pend0));
      reset = 1'b1;
      #1;
      pushExpect("t1_rd_reset", 64'd0);
      pushExpect("t1_pend_reset", 64'd0);
      pushExpect("t1_busy_reset", 64'd0);
      popCompare(64'(rd0[31:0]));
      popCompare(64'(pend0));
      popCompare(64'(busy0));
      #1;
      reset = 1'b0;
      waitCycle();

      // Bypass on the default build, stored value on the non-bypass build
      applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd1, 5'd7);
      w1 = 1'b1; wa1 = 3'd7; wd1 = 64'h12345678; ra1 = 12'(7) << 3;
      #1;
      pushExpect("t2_bypass", 64'h12345678);
      pushExpect("t2_nobypass_before", 64'd0);
      popCompare(64'(rd0[63:32]));
      popCompare(rd1[127:64]);
      waitCycle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd7);
      w1 = 1'b0;
      #1;
      pushExpect("t2_bypass_after", 64'h12345678);
      pushExpect("t2_nobypass_after", 64'h12345678);
      popCompare(64'(rd0[63:32]));
      popCompare(rd1[127:64]);

      // Zero register ignores writes and locks
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
      #1;
      pushExpect("t3_r0_bypass", 64'd0);
      popCompare(64'(rd0[31:0]));
      waitCycle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      pushExpect("t3_r0_read", 64'd0);
      pushExpect("t3_pend0", 64'd0);
      pushExpect("t3_busy", 64'd0);
      popCompare(64'(rd0[31:0]));
      popCompare(64'(pend0[0]));
      popCompare(64'(busy0[0]));

      // Lock r3, hold busy for several cycles, release with a write
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
      #1;
      pushExpect("t4_busy_before_lock", 64'd0);
      popCompare(64'(busy0[0]));
      waitCycle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
      for (int i = 0; i < 3; i++) begin
         pushExpect("t4_busy_held", 64'd1);
         pushExpect("t4_pend_held", 64'(32'h0000_0008));
         popCompare(64'(busy0[0]));
         popCompare(64'(pend0));
         waitCycle();
      end
      applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd0);
      #1;
      pushExpect("t4_busy_release_cycle", 64'd1);
      pushExpect("t4_rd_release_cycle", 64'hA5A5A5A5);
      popCompare(64'(busy0[0]));
      popCompare(64'(rd0[31:0]));
      waitCycle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
      #1;
      pushExpect("t4_busy_released", 64'd0);
      pushExpect("t4_rd_released", 64'hA5A5A5A5);
      popCompare(64'(busy0[0]));
      popCompare(64'(rd0[31:0]));

      // Lock and write of r9 on the same edge: set wins, data lands
      applyStimulus(1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd3, 5'd9);
      waitCycle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9);
      #1;
      pushExpect("t5_pend9", 64'd1);
      pushExpect("t5_busy", 64'd1);
      pushExpect("t5_rd", 64'h00000099);
      popCompare(64'(pend0[9]));
      popCompare(64'(busy0[1]));
      popCompare(64'(rd0[63:32]));

      // Randomised sweep on the wide build against the reference model
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int r = 0; r < 8; r++) model_mem[r] = '0;
      model_pend = '0;
      waitCycle();
      for (int c = 0; c < 10000; c++) begin
         int mode;
         logic [2:0] base;
         w1   = 1'($urandom_range(0, 1));
         wa1  = 3'($urandom_range(0, 7));
         wd1  = {$urandom, $urandom};
         lk1  = ($urandom_range(0, 2) == 0);
         la1  = 3'($urandom_range(0, 7));
         mode = $urandom_range(0, 3);
         base = 3'($urandom_range(0, 7));
         for (int p = 0; p < 4; p++) begin
            if (mode == 0)      ra1[p*3 +: 3] = base;
            else if (mode == 1) ra1[p*3 +: 3] = base + 3'(p);
            else                ra1[p*3 +: 3] = 3'($urandom_range(0, 7));
         end
         for (int p = 0; p < 4; p++) begin
            logic [2:0] a;
            a = ra1[p*3 +: 3];
            pushExpect("sw_rd", (a == 3'd0) ? 64'd0 : model_mem[a]);
            pushExpect("sw_busy", 64'(model_pend[a]));
         end
         pushExpect("sw_pend", 64'(model_pend));
         #1;
         for (int p = 0; p < 4; p++) begin
            popCompare(rd1[p*64 +: 64]);
            popCompare(64'(busy1[p]));
         end
         popCompare(64'(pend1));
         @(posedge clk);
         if (w1 && (wa1 != 3'd0)) model_mem[wa1] = wd1;
         if (w1)  model_pend[wa1] = 1'b0;
         if (lk1) model_pend[la1] = 1'b1;
         model_pend[0] = 1'b0;
         #2;
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
